// File: rtl/reg_access_ctrl.sv
// Host-to-register-bank bus sequencer: turns valid/ready requests into RD/WR/SEL/DATA
// strobes with a turnaround cycle and optional write read-back verification.
module reg_access_ctrl #(
    parameter int WR_CYCLES     = 2,
    parameter int RD_CYCLES     = 1,
    parameter int VERIFY_WRITES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_sel,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt,
    output logic        RD,
    output logic        WR,
    output logic [3:0]  SEL,
    inout  wire  [15:0] DATA
);

    localparam int CNT_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_DRV = 3'd1,
        TURN   = 3'd2,
        RD_STB = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    logic [3:0]         r_sel;
    logic [15:0]        r_wdata;
    logic [15:0]        r_rdata;
    logic               r_err;
    logic [15:0]        r_ok_cnt;
    logic [15:0]        r_err_cnt;
    logic               w_drive;
    logic               w_accept;
    logic               w_capture;

    // 8-bit selects compare a single byte lane of the write data against rb[7:0].
    function automatic logic lane_match(input logic [1:0] grp, input logic [15:0] wd,
                                        input logic [15:0] rb);
        case (grp)
            2'b00:   return (wd[7:0] == rb[7:0]);
            2'b01:   return (wd[15:8] == rb[7:0]);
            default: return (wd == rb);
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        WR        = 1'b0;
        RD        = 1'b0;
        rsp_valid = 1'b0;
        w_drive   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = req_write ? WR_DRV : RD_STB;
            end
            WR_DRV: begin
                WR      = 1'b1;
                w_drive = 1'b1;
                if (r_cnt == '0) w_next = TURN;
            end
            TURN: begin
                w_next = (VERIFY_WRITES != 0) ? RD_STB : RESP;
            end
            RD_STB: begin
                RD = 1'b1;
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_capture = (r_state == RD_STB) && (r_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_sel     <= 4'd0;
            r_wdata   <= 16'd0;
            r_rdata   <= 16'd0;
            r_err     <= 1'b0;
            r_ok_cnt  <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_sel   <= req_sel;
                r_wdata <= req_wdata;
                r_rdata <= 16'd0;
                r_err   <= 1'b0;
                r_cnt   <= req_write ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);
            end else if (r_state == TURN) begin
                r_cnt <= CNT_W'(RD_CYCLES - 1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // Unknown bus bits fall into the else branch and are flagged as a mismatch.
            if (w_capture) begin
                r_rdata <= DATA;
                if (r_write) begin
                    if (lane_match(r_sel[3:2], r_wdata, DATA)) r_err <= 1'b0;
                    else                                       r_err <= 1'b1;
                end
            end

            if ((r_state == RESP) && r_write && (VERIFY_WRITES != 0)) begin
                if (r_err) r_err_cnt <= sat_inc(r_err_cnt);
                else       r_ok_cnt  <= sat_inc(r_ok_cnt);
            end
        end
    end

    assign DATA      = w_drive ? r_wdata : 16'bz;
    assign SEL       = r_sel;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign ok_cnt    = r_ok_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
